// File: rtl/alu_pkg.sv
// Shared ALU/branch control codes and execute-unit state encoding.
// The control decoder imports these same constants so the codes stay in sync.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch compare codes, only meaningful when iBranch=1 (BEQ aliases SUB).
  localparam logic [3:0] BR_BEQ  = 4'b1000;
  localparam logic [3:0] BR_BNE  = 4'b1100;
  localparam logic [3:0] BR_BLT  = 4'b1010;
  localparam logic [3:0] BR_BGE  = 4'b1110;
  localparam logic [3:0] BR_BLTU = 4'b1011;
  localparam logic [3:0] BR_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative one-bit-per-cycle shifter; 'result' is the value after the current cycle's step.
// 'done' is high in the cycle whose clock edge performs the final step; abort clears it at once.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [SHW-1:0]  amount,
  input  logic [XLEN-1:0] operand,
  input  logic            right,
  input  logic            arith,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sh_q;
  logic [SHW-1:0]  cnt_q;
  logic            right_q;
  logic            arith_q;

  assign busy   = (cnt_q != '0);
  assign done   = (cnt_q == SHW'(1));
  assign result = right_q ? {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]}
                          : {sh_q[XLEN-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      sh_q    <= operand;
      cnt_q   <= amount;
      right_q <= right;
      arith_q <= arith;
    end else if (busy) begin
      sh_q  <= result;
      cnt_q <= cnt_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle add/sub/logic/compare, n+1-cycle iterative shifts, registered outputs.
// Valid/ready both sides; result held in DONE until iReady, next op may be accepted on that same cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  output logic            oReady,
  input  logic [3:0]      iAluCtrl,
  input  logic            iBranch,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oTaken,
  output logic            oZero
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d, alu_res, diff, seq_result;
  logic            taken_q, taken_d, zero_q, alu_taken;
  logic            res_load, seq_start, seq_busy, seq_done;
  logic            accept, is_shift, lt_s, lt_u, eq;
  logic [SHW-1:0]  amount;

  assign diff     = iA - iB;
  assign lt_s     = $signed(iA) < $signed(iB);
  assign lt_u     = iA < iB;
  assign eq       = (iA == iB);
  assign amount   = iB[SHW-1:0];
  assign is_shift = !iBranch &&
                    (iAluCtrl == ALU_SLL || iAluCtrl == ALU_SRL || iAluCtrl == ALU_SRA);

  assign oReady = (state_q == IDLE) || (state_q == DONE && iReady);
  assign accept = iValid && oReady && !iFlush;
  assign oValid  = (state_q == DONE);
  assign oResult = res_q;
  assign oTaken  = taken_q;
  assign oZero   = zero_q;

  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    if (iBranch) begin
      alu_res = diff;
      case (iAluCtrl)
        BR_BEQ:  alu_taken = eq;
        BR_BNE:  alu_taken = !eq;
        BR_BLT:  alu_taken = lt_s;
        BR_BGE:  alu_taken = !lt_s;
        BR_BLTU: alu_taken = lt_u;
        BR_BGEU: alu_taken = !lt_u;
        default: alu_taken = 1'b0;
      endcase
    end else begin
      case (iAluCtrl)
        ALU_ADD:                   alu_res = iA + iB;
        ALU_SUB:                   alu_res = diff;
        ALU_SLL, ALU_SRL, ALU_SRA: alu_res = iA;  // zero-amount shift passes A through
        ALU_SLT:                   alu_res = {{(XLEN-1){1'b0}}, lt_s};
        ALU_SLTU:                  alu_res = {{(XLEN-1){1'b0}}, lt_u};
        ALU_XOR:                   alu_res = iA ^ iB;
        ALU_OR:                    alu_res = iA | iB;
        ALU_AND:                   alu_res = iA & iB;
        default:                   alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    res_load  = 1'b0;
    res_d     = res_q;
    taken_d   = taken_q;
    seq_start = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (seq_done) begin
          res_load = 1'b1;
          res_d    = seq_result;
          taken_d  = 1'b0;
          state_d  = DONE;
        end else if (!seq_busy) begin
          state_d = IDLE;  // shifter lost its operation; never leave the FSM stranded
        end
      end
      DONE:    if (iReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (is_shift && amount != '0) begin
        seq_start = 1'b1;
        state_d   = SHIFT;
      end else begin
        res_load = 1'b1;
        res_d    = alu_res;
        taken_d  = alu_taken;
        state_d  = DONE;
      end
    end
    if (iFlush) state_d = IDLE;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      res_q   <= '0;
      taken_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (res_load) begin
        res_q   <= res_d;
        taken_q <= taken_d;
        zero_q  <= (res_d == '0);
      end
    end
  end

  alu_shift_seq #(.XLEN(XLEN), .SHW(SHW)) u_shift_seq (
    .clk     (iClk),
    .rst_n   (iRstN),
    .start   (seq_start),
    .abort   (iFlush),
    .amount  (amount),
    .operand (iA),
    .right   (iAluCtrl[3]),
    .arith   (iAluCtrl[2]),
    .busy    (seq_busy),
    .done    (seq_done),
    .result  (seq_result)
  );

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that takes the 4-bit ALU control code from the ALU control decoder, together with two operands, and produces a registered result plus a branch-taken flag for the writeback and PC-select logic. Add, subtract, logic, set-less-than and compare operations complete in one cycle. Shifts run iteratively at one bit per cycle, which keeps the barrel shifter out of the datapath. A valid/ready handshake on both sides lets the pipeline stall around multi-cycle shifts.

## Interface
Parameters:
- XLEN, 32, operand/result width
- SHW, $clog2(XLEN), shift-amount width

Ports:
- iClk  in  1  clock; all state on rising edge
- iRstN  in  1  asynchronous active-low reset
- iValid  in  1  upstream operation valid
- oReady  out  1  unit can accept an operation this cycle
- iAluCtrl  in  4  ALU control code from the ALU control decoder
- iBranch  in  1  1 = treat iAluCtrl as a branch compare code
- iA  in  XLEN  operand A (rs1 or PC)
- iB  in  XLEN  operand B (rs2 or immediate)
- iFlush  in  1  synchronous kill of any in-flight or held operation
- oValid  out  1  oResult/oTaken valid
- iReady  in  1  downstream accepts the result
- oResult  out  XLEN  registered result
- oTaken  out  1  branch condition true (0 when iBranch was 0)
- oZero  out  1  oResult == 0

## Operation
- Codes with iBranch=0:
  - ADD 0000, SUB 1000
  - SLL 0001, SRL 1001, SRA 1101
  - SLT 0010, SLTU 0011
  - XOR 0100, OR 0110, AND 0111
  - Any other code: result 0.
- Codes with iBranch=1:
  - BEQ 1000, BNE 1100, BLT 1010, BGE 1110, BLTU 1011, BGEU 1111.
  - oResult = A−B.
  - oTaken = the compare (signed for BLT/BGE, unsigned for BLTU/BGEU).
  - Any other code: oTaken 0.
  - Code 1000 is shared by SUB and BEQ; iBranch is the sole disambiguator.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU write 1 or 0 zero-extended.
  - Shift amount = iB[SHW-1:0]; upper bits of iB are ignored.
  - SRA replicates the sign bit.
- State machine (states IDLE, SHIFT, DONE):
  - IDLE, accepting a non-shift op: compute and register the result, go to DONE.
  - IDLE, accepting a shift with amount 0: register iA unchanged, go to DONE.
  - IDLE, accepting a shift with amount n>0: latch iA, n and the direction, go to SHIFT.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: oValid=1. Outputs hold stable until iReady. On iReady, go to IDLE, or accept the next op in the same cycle if iValid.
- Handshake:
  - oReady = (state==IDLE) || (state==DONE && iReady).
  - Transfer in occurs when iValid && oReady.
  - Transfer out occurs when oValid && iReady.
  - In DONE, oResult, oTaken and oZero do not change while iReady=0.
- Flush:
  - iFlush=1 forces IDLE next cycle from any state and drops oValid.
  - iFlush has priority over acceptance; an op presented in the same cycle is discarded.
- Reset (iRstN low, asynchronous): state IDLE, oValid 0, oResult 0, oTaken 0, oZero 1, shift counter 0. oReady is 1 from the first cycle after deassertion.

## Timing
- Non-shift and zero-amount shift: oValid rises 1 cycle after acceptance.
- Shift by n>0: oValid rises n+1 cycles after acceptance. Maximum latency is XLEN cycles (n = XLEN−1).
- Back-to-back non-shift ops with iReady held at 1: one result per cycle.
- oReady is 0 throughout SHIFT.
- oZero and oTaken are registered alongside oResult; there are no combinational paths from inputs to outputs except oReady←iReady.
- Reset asserted mid-shift aborts immediately, with no partial result visible.

## Structure
- Shared package alu_pkg holds:
  - the sixteen 4-bit ALU/branch control code localparams;
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- The ALU control decoder imports the same package, so the codes cannot drift.
- One sub-module, alu_shift_seq, contains the shift register, counter and direction/arith flags. Its interface is start/amount/operand in, busy/done/result out.
- Everything else (adder, compare, logic, FSM) is a single module.

## Test plan
1. ADD: A=0x7FFFFFFF, B=1 -> oResult=0x80000000 one cycle later, oZero=0. SUB: A=5, B=5 -> 0, oZero=1.
2. Branch BLT (1010) with iBranch=1, A=0xFFFFFFFF, B=1 -> oTaken=1. Same operands with BLTU (1011) -> oTaken=0. SUB code 1000 with iBranch=0 -> oTaken=0.
3. SRA, A=0x80000000, B=0x1F -> oReady low for 31 cycles, oValid on cycle 32, oResult=0xFFFFFFFF. SLL with B=0x20 (amount 0) -> 1-cycle latency, oResult=A.
4. Backpressure: hold iReady=0 for 5 cycles in DONE -> oResult stable, oReady=0; raise iReady with a new iValid -> new op accepted in the same cycle.
5. iFlush mid-shift (SLL, A=1, B=10, at cycle 4) -> IDLE next cycle, no oValid pulse; the next ADD completes normally.
6. Async reset asserted mid-SHIFT -> oValid=0, oResult=0, oZero=1 immediately. After release, oReady=1 and AND 0xF0F0 & 0x0FF0 = 0x00F0.
